// File: rtl/line_pixel_writer.sv
// Consumes (X,Y) positions from the line rasteriser, clips them to the screen and
// writes the latched colour to the frame buffer through a req/ack port.
module line_pixel_writer #(
  parameter int H_RES   = 800,
  parameter int X_MAX   = 799,
  parameter int Y_MAX   = 599,
  parameter int SETTLE  = 2,
  parameter int ADDR_W  = 20,
  parameter int MAX_PIX = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       i_color,
  input  logic              i_abort,
  input  logic [9:0]        i_X_pos,
  input  logic [9:0]        i_Y_pos,
  input  logic              i_done,
  output logic              o_renew,
  output logic              o_wr_req,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data,
  input  logic              i_wr_ack,
  output logic              o_busy,
  output logic              o_line_done,
  output logic              o_overflow,
  output logic [11:0]       o_pix_cnt
);

  localparam logic [9:0]        X_MAX_L   = 10'(X_MAX);
  localparam logic [9:0]        Y_MAX_L   = 10'(Y_MAX);
  localparam logic [ADDR_W-1:0] H_RES_L   = ADDR_W'(H_RES);
  localparam logic [2:0]        SETTLE_M1 = 3'(SETTLE - 1);
  localparam logic [11:0]       MAX_PIX_L = 12'(MAX_PIX);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RENEW  = 3'd1,
    WAIT   = 3'd2,
    CHECK  = 3'd3,
    WRITE  = 3'd4,
    NEXT   = 3'd5,
    FINISH = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        wait_q, wait_d;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic              done_q, done_d;
  logic [15:0]       color_q, color_d;
  logic [ADDR_W-1:0] prod_q, prod_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              chk_ph_q, chk_ph_d;
  logic              in_range_q, in_range_d;
  logic [11:0]       cons_q, cons_d;
  logic [11:0]       pix_q, pix_d;
  logic              ovf_q, ovf_d;
  logic              abort_pend_q, abort_pend_d;
  logic              renew_q, renew_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              line_done_q, line_done_d;

  // Next-state and datapath update; strobes are decoded from the next state so they register in step with it.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    x_d          = x_q;
    y_d          = y_q;
    done_d       = done_q;
    color_d      = color_q;
    prod_d       = prod_q;
    addr_d       = addr_q;
    chk_ph_d     = chk_ph_q;
    in_range_d   = in_range_q;
    cons_d       = cons_q;
    pix_d        = pix_q;
    ovf_d        = ovf_q;
    abort_pend_d = abort_pend_q;

    case (state_q)
      IDLE: begin
        if (start && !i_abort) begin
          state_d      = RENEW;
          color_d      = i_color;
          pix_d        = 12'd0;
          cons_d       = 12'd0;
          ovf_d        = 1'b0;
          abort_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RENEW: begin
        wait_d = SETTLE_M1;
        if (i_abort) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (wait_q == 3'd0) begin
          x_d      = i_X_pos;
          y_d      = i_Y_pos;
          done_d   = i_done;
          chk_ph_d = 1'b0;
          state_d  = CHECK;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      CHECK: begin
        // First cycle registers the row product, second adds X and branches.
        if (i_abort) begin
          state_d  = IDLE;
          chk_ph_d = 1'b0;
        end else if (!chk_ph_q) begin
          cons_d     = cons_q + 12'd1;
          in_range_d = (x_q <= X_MAX_L) && (y_q <= Y_MAX_L);
          prod_d     = ADDR_W'(y_q) * H_RES_L;
          chk_ph_d   = 1'b1;
        end else begin
          addr_d   = prod_q + ADDR_W'(x_q);
          chk_ph_d = 1'b0;
          if (in_range_q) begin
            state_d = WRITE;
          end else begin
            state_d = NEXT;
          end
        end
      end
      WRITE: begin
        // An abort here only takes effect once the outstanding write is acknowledged.
        if (i_abort) begin
          abort_pend_d = 1'b1;
        end else begin
          abort_pend_d = abort_pend_q;
        end
        if (i_wr_ack) begin
          pix_d        = (pix_q == 12'hFFF) ? pix_q : pix_q + 12'd1;
          abort_pend_d = 1'b0;
          if (abort_pend_q || i_abort) begin
            state_d = IDLE;
          end else begin
            state_d = NEXT;
          end
        end else begin
          state_d = WRITE;
        end
      end
      NEXT: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (done_q) begin
          state_d = FINISH;
        end else if (cons_q == MAX_PIX_L) begin
          state_d = FINISH;
          ovf_d   = 1'b1;
        end else begin
          state_d = RENEW;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    renew_d     = (state_d == RENEW);
    req_d       = (state_d == WRITE);
    busy_d      = (state_d != IDLE);
    line_done_d = (state_d == FINISH);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wait_q       <= 3'd0;
      x_q          <= 10'd0;
      y_q          <= 10'd0;
      done_q       <= 1'b0;
      color_q      <= 16'd0;
      prod_q       <= '0;
      addr_q       <= '0;
      chk_ph_q     <= 1'b0;
      in_range_q   <= 1'b0;
      cons_q       <= 12'd0;
      pix_q        <= 12'd0;
      ovf_q        <= 1'b0;
      abort_pend_q <= 1'b0;
      renew_q      <= 1'b0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      line_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      x_q          <= x_d;
      y_q          <= y_d;
      done_q       <= done_d;
      color_q      <= color_d;
      prod_q       <= prod_d;
      addr_q       <= addr_d;
      chk_ph_q     <= chk_ph_d;
      in_range_q   <= in_range_d;
      cons_q       <= cons_d;
      pix_q        <= pix_d;
      ovf_q        <= ovf_d;
      abort_pend_q <= abort_pend_d;
      renew_q      <= renew_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      line_done_q  <= line_done_d;
    end
  end

  assign o_renew     = renew_q;
  assign o_wr_req    = req_q;
  assign o_wr_addr   = addr_q;
  assign o_wr_data   = color_q;
  assign o_busy      = busy_q;
  assign o_line_done = line_done_q;
  assign o_overflow  = ovf_q;
  assign o_pix_cnt   = pix_q;

endmodule

// File: tb/tb_line_pixel_writer.sv
// Directed bench for line_pixel_writer: a table of single-pixel lines plus
// hand-written sequences for reset, clipping, ack delay, abort and overflow.
module tb_line_pixel_writer;

  logic        clk, rst, start, i_abort, i_done, i_wr_ack;
  logic [15:0] i_color;
  logic [9:0]  i_X_pos, i_Y_pos;
  logic        o_renew, o_wr_req, o_busy, o_line_done, o_overflow;
  logic [19:0] o_wr_addr;
  logic [15:0] o_wr_data;
  logic [11:0] o_pix_cnt;

  line_pixel_writer #(.MAX_PIX(4)) dut (
    .clk(clk), .rst(rst), .start(start), .i_color(i_color), .i_abort(i_abort),
    .i_X_pos(i_X_pos), .i_Y_pos(i_Y_pos), .i_done(i_done),
    .o_renew(o_renew), .o_wr_req(o_wr_req), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .i_wr_ack(i_wr_ack), .o_busy(o_busy), .o_line_done(o_line_done),
    .o_overflow(o_overflow), .o_pix_cnt(o_pix_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // producer table and monitor state
  logic [9:0] px [8];
  logic [9:0] py [8];
  logic       pd [8];
  int         pi = 0;
  int         ack_delay = 0;
  int         req_age = 0;
  int         renew_cnt = 0;
  int         ld_cnt = 0;
  int         hold_len = 0;
  int         addr_changed = 0;
  int         last_ack_cyc = 0;
  int         ld_cyc = 0;
  logic [19:0] first_addr;
  logic [19:0] wq_a [$];
  logic [15:0] wq_d [$];

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] color;
    logic        exp_wr;
    logic [19:0] exp_addr;
    logic [11:0] exp_pix;
  } vec_t;
  vec_t vt [7];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // producer: presents the next table entry after each o_renew
  initial begin
    forever begin
      @(negedge clk);
      if (o_renew && pi < 8) begin
        i_X_pos = px[pi];
        i_Y_pos = py[pi];
        i_done  = pd[pi];
        pi++;
      end
    end
  end

  // SRAM responder and write/pulse monitor
  initial begin
    forever begin
      @(negedge clk);
      if (o_wr_req) begin
        if (req_age == 0) first_addr = o_wr_addr;
        else if (o_wr_addr != first_addr) addr_changed++;
        i_wr_ack = (req_age == ack_delay);
        req_age++;
        if (i_wr_ack) begin
          wq_a.push_back(o_wr_addr);
          wq_d.push_back(o_wr_data);
          hold_len = req_age;
          last_ack_cyc = cyc;
        end
      end else begin
        i_wr_ack = 1'b0;
        req_age = 0;
      end
      if (o_renew) renew_cnt++;
      if (o_line_done) begin
        ld_cnt++;
        ld_cyc = cyc;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    wq_a.delete();
    wq_d.delete();
    renew_cnt = 0;
    ld_cnt = 0;
    pi = 0;
    hold_len = 0;
    addr_changed = 0;
  endtask

  task automatic set_pos(input int k, input logic [9:0] x, input logic [9:0] y, input logic d);
    px[k] = x;
    py[k] = y;
    pd[k] = d;
  endtask

  task automatic start_line(input logic [15:0] col);
    @(negedge clk);
    i_color = col;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (o_busy && n < 600);
    chk(nm, {31'd0, o_busy}, 32'd0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!o_wr_req && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(nm, {31'd0, o_wr_req}, 32'd1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; i_abort = 1'b0; i_done = 1'b0; i_wr_ack = 1'b0;
    i_color = 16'd0; i_X_pos = 10'd0; i_Y_pos = 10'd0;
    for (int k = 0; k < 8; k++) set_pos(k, 10'd0, 10'd0, 1'b0);

    vt[0] = '{10'd0,    10'd0,    16'h1234, 1'b1, 20'd0,      12'd1};
    vt[1] = '{10'd799,  10'd0,    16'h00FF, 1'b1, 20'd799,    12'd1};
    vt[2] = '{10'd0,    10'd599,  16'hABCD, 1'b1, 20'd479200, 12'd1};
    vt[3] = '{10'd123,  10'd45,   16'h5A5A, 1'b1, 20'd36123,  12'd1};
    vt[4] = '{10'd1023, 10'd0,    16'hFFFF, 1'b0, 20'd0,      12'd0};
    vt[5] = '{10'd0,    10'd1023, 16'h0001, 1'b0, 20'd0,      12'd0};
    vt[6] = '{10'd799,  10'd599,  16'h07E0, 1'b1, 20'd479999, 12'd1};

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outs", {o_renew, o_wr_req, o_busy, o_line_done, o_overflow}, 32'd0);
    chk("rst_addr", {12'd0, o_wr_addr}, 32'd0);
    chk("rst_data_cnt", {o_wr_data, 4'd0, o_pix_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // table of single-pixel lines
    for (int v = 0; v < 7; v++) begin
      clear_mon();
      ack_delay = 0;
      set_pos(0, vt[v].x, vt[v].y, 1'b1);
      start_line(vt[v].color);
      wait_idle("vec_timeout");
      chk("vec_nwrites", wq_a.size(), {31'd0, vt[v].exp_wr});
      if (vt[v].exp_wr && wq_a.size() > 0) begin
        chk("vec_addr", {12'd0, wq_a[0]}, {12'd0, vt[v].exp_addr});
        chk("vec_data", {16'd0, wq_d[0]}, {16'd0, vt[v].color});
      end
      chk("vec_pix", {20'd0, o_pix_cnt}, {20'd0, vt[v].exp_pix});
      chk("vec_line_done", ld_cnt, 32'd1);
    end

    // T2: three pixels on row 5
    clear_mon();
    set_pos(0, 10'd10, 10'd5, 1'b0);
    set_pos(1, 10'd11, 10'd5, 1'b0);
    set_pos(2, 10'd12, 10'd5, 1'b1);
    start_line(16'hF800);
    wait_idle("t2_timeout");
    chk("t2_nwrites", wq_a.size(), 32'd3);
    if (wq_a.size() == 3) begin
      chk("t2_addr0", {12'd0, wq_a[0]}, 32'd4010);
      chk("t2_addr1", {12'd0, wq_a[1]}, 32'd4011);
      chk("t2_addr2", {12'd0, wq_a[2]}, 32'd4012);
      chk("t2_data2", {16'd0, wq_d[2]}, 32'h0000F800);
    end
    chk("t2_pix", {20'd0, o_pix_cnt}, 32'd3);
    chk("t2_renews", renew_cnt, 32'd3);
    chk("t2_line_done", ld_cnt, 32'd1);
    // ack cycle, NEXT cycle, then FINISH raises o_line_done
    chk("t2_ld_delay", ld_cyc - last_ack_cyc, 32'd2);

    // T3: clipping at the screen edges
    clear_mon();
    set_pos(0, 10'd799, 10'd599, 1'b0);
    set_pos(1, 10'd800, 10'd10,  1'b0);
    set_pos(2, 10'd5,   10'd600, 1'b1);
    start_line(16'h001F);
    wait_idle("t3_timeout");
    chk("t3_nwrites", wq_a.size(), 32'd1);
    if (wq_a.size() == 1) chk("t3_addr", {12'd0, wq_a[0]}, 32'd479999);
    chk("t3_pix", {20'd0, o_pix_cnt}, 32'd1);
    chk("t3_line_done", ld_cnt, 32'd1);

    // T4: ack delayed 5 cycles
    clear_mon();
    ack_delay = 5;
    set_pos(0, 10'd7, 10'd2, 1'b1);
    start_line(16'h0F0F);
    wait_idle("t4_timeout");
    chk("t4_hold", hold_len, 32'd6);
    chk("t4_addr_stable", addr_changed, 32'd0);
    chk("t4_renews", renew_cnt, 32'd1);
    chk("t4_pix", {20'd0, o_pix_cnt}, 32'd1);
    ack_delay = 0;

    // T5a: abort in WAIT
    clear_mon();
    set_pos(0, 10'd1, 10'd1, 1'b1);
    start_line(16'h1111);
    for (int n = 0; n < 20 && renew_cnt == 0; n++) begin
      @(negedge clk);
      #1;
    end
    chk("t5a_renew_seen", renew_cnt, 32'd1);
    @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    #1;
    chk("t5a_idle_next", {31'd0, o_busy}, 32'd0);
    repeat (15) @(negedge clk);
    #1;
    chk("t5a_nwrites", wq_a.size(), 32'd0);
    chk("t5a_line_done", ld_cnt, 32'd0);

    // T5b: abort during WRITE with a late ack
    clear_mon();
    ack_delay = 3;
    set_pos(0, 10'd2, 10'd3, 1'b0);
    set_pos(1, 10'd3, 10'd3, 1'b1);
    start_line(16'h2222);
    wait_req("t5b_req_seen");
    @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    wait_idle("t5b_timeout");
    chk("t5b_nwrites", wq_a.size(), 32'd1);
    if (wq_a.size() == 1) chk("t5b_addr", {12'd0, wq_a[0]}, 32'd2402);
    chk("t5b_renews", renew_cnt, 32'd1);
    chk("t5b_line_done", ld_cnt, 32'd0);
    ack_delay = 0;

    // T5c: start and abort together
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    i_abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    i_abort = 1'b0;
    #1;
    chk("t5c_busy", {31'd0, o_busy}, 32'd0);
    repeat (5) @(negedge clk);
    chk("t5c_renews", renew_cnt, 32'd0);

    // T1: reset mid-write
    clear_mon();
    ack_delay = 20;
    set_pos(0, 10'd4, 10'd4, 1'b1);
    start_line(16'h3333);
    wait_req("t1_req_seen");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t1_outs_low", {o_wr_req, o_busy, o_renew}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ack_delay = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("t1_idle_after", {o_busy, o_wr_req, o_renew}, 32'd0);

    // T6: producer never raises done; guard is 4 positions
    clear_mon();
    for (int k = 0; k < 8; k++) set_pos(k, 10'(k + 1), 10'd1, 1'b0);
    start_line(16'h4444);
    wait_idle("t6_timeout");
    chk("t6_nwrites", wq_a.size(), 32'd4);
    if (wq_a.size() == 4) chk("t6_last_addr", {12'd0, wq_a[3]}, 32'd804);
    chk("t6_overflow", {31'd0, o_overflow}, 32'd1);
    chk("t6_line_done", ld_cnt, 32'd1);
    chk("t6_renews", renew_cnt, 32'd4);
    chk("t6_pix", {20'd0, o_pix_cnt}, 32'd4);
    clear_mon();
    set_pos(0, 10'd9, 10'd9, 1'b1);
    start_line(16'h5555);
    #1;
    chk("t6_ovf_cleared", {31'd0, o_overflow}, 32'd0);
    wait_idle("t6b_timeout");
    chk("t6b_overflow", {31'd0, o_overflow}, 32'd0);
    chk("t6b_pix", {20'd0, o_pix_cnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
